// File: rtl/fp_pkg.sv
// fp_pkg: shared half-precision format constants and divider state encoding
package fp_pkg;
  localparam int EXPONENT_WIDTH = 5;
  localparam int MANTISSA_WIDTH = 10;
  localparam int BIAS = 2 ** (EXPONENT_WIDTH - 1) - 1;
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
endpackage

// File: rtl/fp_div.sv
// fp_div: multi-cycle floating-point divider using restoring mantissa division with truncation
module fp_div
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = fp_pkg::EXPONENT_WIDTH,
  parameter int MANTISSA_WIDTH = fp_pkg::MANTISSA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_b,
  output logic                                   sign,
  output logic [EXPONENT_WIDTH-1:0]              exponent,
  output logic [MANTISSA_WIDTH-1:0]              quot,
  output logic                                   busy,
  output logic                                   done
);
  localparam int M = MANTISSA_WIDTH;
  localparam int E = EXPONENT_WIDTH;
  localparam int CW = $clog2(M + 2);
  localparam int EXP_BIAS = 2 ** (E - 1) - 1;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [M+1:0]   rem;
  logic [M+1:0]   q;
  logic [M:0]     mb;
  logic [E-1:0]   ea;
  logic [E-1:0]   eb;
  logic           sgn;
  logic           zero_a;
  logic           zero_b;
  logic           ge;
  logic [M+1:0]   r_sub;
  logic [E-1:0]   e_norm;
  assign busy = state != IDLE;
  // One restoring step; the exponent is only needed modulo 2^E, so the wider signed sum truncates to this
  always_comb begin
    ge = rem >= {1'b0, mb};
    r_sub = ge ? rem - {1'b0, mb} : rem;
    e_norm = ea - eb + E'(EXP_BIAS) - E'(!q[M+1]);
  end
  // Control FSM with datapath registers: capture, iterate M+2 quotient bits, normalise, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      q <= '0;
      mb <= '0;
      ea <= '0;
      eb <= '0;
      sgn <= 1'b0;
      zero_a <= 1'b0;
      zero_b <= 1'b0;
      sign <= 1'b0;
      exponent <= '0;
      quot <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= DIVIDE;
          cnt <= '0;
          q <= '0;
          rem <= {1'b0, 1'b1, flp_a[M-1:0]};
          mb <= {1'b1, flp_b[M-1:0]};
          ea <= flp_a[E+M-1:M];
          eb <= flp_b[E+M-1:M];
          sgn <= flp_a[E+M] ^ flp_b[E+M];
          zero_a <= ~|flp_a[E+M-1:0];
          zero_b <= ~|flp_b[E+M-1:0];
        end
        DIVIDE: begin
          q <= {q[M:0], ge};
          rem <= r_sub << 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(M + 1)) state <= NORM;
        end
        NORM: begin
          state <= DONE;
          done <= 1'b1;
          sign <= zero_a ? 1'b0 : sgn;
          exponent <= zero_a ? '0 : zero_b ? '1 : e_norm;
          quot <= (zero_a || zero_b) ? '0 : q[M+1] ? q[M:1] : q[M-1:0];
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed table, handshake/reset sequences and random ops against an arithmetic reference
module tb_fp_div;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] flp_a = '0;
  logic [15:0] flp_b = '0;
  logic        sign;
  logic [4:0]  exponent;
  logic [9:0]  quot;
  logic        busy;
  logic        done;
  int n_cmp = 0;
  int n_bad = 0;
  fp_div dut (
    .clk(clk), .rst(rst), .start(start), .flp_a(flp_a), .flp_b(flp_b),
    .sign(sign), .exponent(exponent), .quot(quot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ma, mb, qq, e;
    if (a[14:0] == 0) return 16'h0000;
    if (b[14:0] == 0) return {a[15] ^ b[15], 5'h1f, 10'h000};
    ma = 1024 + int'(a[9:0]);
    mb = 1024 + int'(b[9:0]);
    qq = ma * 2048 / mb;
    e = int'(a[14:10]) - int'(b[14:10]) + 15 - (qq >= 2048 ? 0 : 1);
    return {a[15] ^ b[15], 5'(e), qq >= 2048 ? 10'(qq >> 1) : 10'(qq)};
  endfunction
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    flp_a = a;
    flp_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    flp_a = 16'($urandom);
    flp_b = 16'($urandom);
  endtask
  task automatic wait_done(input string name, input logic [15:0] want);
    int lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd13);
    chk(name, {16'h0, sign, exponent, quot}, {16'h0, want});
  endtask
  initial begin
    vec_t vecs[6];
    logic [15:0] a, b, held;
    int dones;
    vecs[0] = '{16'h4600, 16'h4000, 16'h4200};
    vecs[1] = '{16'h3C00, 16'h4200, 16'h3555};
    vecs[2] = '{16'hC200, 16'h3E00, 16'hC000};
    vecs[3] = '{16'h0000, 16'h4000, 16'h0000};
    vecs[4] = '{16'h3C00, 16'h0000, 16'h7C00};
    vecs[5] = '{16'h0000, 16'h0000, 16'h0000};
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_outputs", {16'h0, sign, exponent, quot}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].r);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    flp_a = 16'h4600;
    flp_b = 16'h4000;
    start = 1'b1;
    dones = 0;
    held = 16'h0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      flp_a = 16'($urandom);
      flp_b = 16'($urandom);
      if (done) begin
        dones++;
        held = {sign, exponent, quot};
      end
      if (k == 14) start = 1'b0;
    end
    chk("ignored_starts_dones", 32'(dones), 32'd1);
    chk("ignored_starts_result", {16'h0, held}, 32'h4200);
    chk("ignored_starts_hold", {16'h0, sign, exponent, quot}, 32'h4200);
    launch(16'h3C00, 16'h4200);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_outputs", {16'h0, sign, exponent, quot}, 32'h0);
    flp_a = 16'hC200;
    flp_b = 16'h3E00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done("restart", 16'hC000);
    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      a[14:10] = 5'($urandom_range(1, 30));
      b[14:10] = 5'($urandom_range(1, 30));
      if ($urandom_range(0, 15) == 0) a[14:0] = '0;
      if ($urandom_range(0, 15) == 0) b[14:0] = '0;
      launch(a, b);
      wait_done($sformatf("rand_%h_%h", a, b), ref_div(a, b));
      @(posedge clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 Parameter EXPONENT_WIDTH, default 5: exponent field width (IEEE half).
REQ-002 Parameter MANTISSA_WIDTH, default 10: stored fraction width (hidden bit excluded); M below denotes this value.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 flp_a  input  EXPONENT_WIDTH+M+1  dividend; fields {sign, exponent, fraction}.
REQ-007 flp_b  input  EXPONENT_WIDTH+M+1  divisor; same field layout.
REQ-008 sign  output  1  quotient sign, registered.
REQ-009 exponent  output  EXPONENT_WIDTH  quotient biased exponent, registered.
REQ-010 quot  output  M  quotient fraction, hidden bit excluded, registered.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.

Function
REQ-013 States SHALL be IDLE, DIVIDE, NORM and DONE.
- IDLE->DIVIDE on start.
- DIVIDE->NORM after M+2 iterations.
- NORM->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-014 On the edge sampling start in IDLE, the block SHALL capture flp_a and flp_b; later input changes SHALL not affect the result.
REQ-015 start while busy=1 (including the DONE cycle) SHALL be ignored.
REQ-016 Latency SHALL be fixed: done is registered high by the 13th rising edge (M+3) after the edge that sampled start, for every operand value.
REQ-017 Mantissas ma={1,frac_a} and mb={1,frac_b} (M+1 bits each) SHALL be divided by restoring division, one quotient bit per DIVIDE cycle, MSB first.
REQ-018 The division SHALL produce q = floor(ma*2^(M+1)/mb), an (M+2)-bit quotient.
REQ-019 Normalisation in NORM SHALL use q[M+1]:
- q[M+1]=1: quot=q[M:1], exponent=ea-eb+bias.
- q[M+1]=0: quot=q[M-1:0], exponent=ea-eb+bias-1.
- bias = 2^(EXPONENT_WIDTH-1)-1.
REQ-020 Rounding SHALL be truncation; remainder bits are discarded.
REQ-021 Exponent SHALL be computed in EXPONENT_WIDTH+2-bit signed arithmetic, then truncated to the low EXPONENT_WIDTH bits; there is no overflow/underflow detection and no denormal support.
REQ-022 sign SHALL equal sign_a XOR sign_b.
REQ-023 If flp_a magnitude bits (all except sign) are zero, the result SHALL be sign=0, exponent=0, quot=0; this check has priority over REQ-024.
REQ-024 Otherwise, if flp_b magnitude bits are zero, the result SHALL be infinity: sign=sign_a XOR sign_b, exponent all ones, quot=0.
REQ-025 Special cases SHALL still obey the REQ-016 latency.
REQ-026 sign, exponent and quot SHALL update only on the edge entering DONE and SHALL hold until the next completion.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and set busy=0, done=0, sign=0, exponent=0, quot=0, and clear all internal registers.
REQ-028 rst during DIVIDE, NORM or DONE SHALL abort the operation with no done pulse; a start on the first cycle after reset release SHALL be accepted.
REQ-029 rst SHALL have priority over start in the same cycle.

Structure
REQ-030 Shared package fp_pkg SHALL hold EXPONENT_WIDTH, MANTISSA_WIDTH, the bias constant and the state enumeration, for reuse by fpMul users.
REQ-031 No sub-module is required; the iteration counter, remainder and partial quotient SHALL live in fp_div.

Verification
REQ-032 0x4600/0x4000 (6.0/2.0) -> done at edge +13; sign=0, exponent=5'b10000, quot=10'h200 (0x4200).
REQ-033 0x3C00/0x4200 (1.0/3.0) -> sign=0, exponent=5'b01101, quot=10'h155 (0x3555, normalise-down path).
REQ-034 0xC200/0x3E00 (-3.0/1.5) -> sign=1, exponent=5'b10000, quot=0 (-2.0).
REQ-035 Zero/infinity cases:
- 0x0000/0x4000 -> all outputs zero.
- 0x3C00/0x0000 -> sign=0, exponent=5'b11111, quot=0.
- 0x0000/0x0000 -> all outputs zero.
REQ-036 Handshake and reset:
- start pulsed every cycle while busy -> exactly one done per accepted operation, results unchanged by ignored starts.
- rst asserted at DIVIDE cycle 5 -> no done, all outputs 0.
- New start after reset release -> correct result at +13.
